terminate_issue_queue: RTL and testbench

//  In-order issue queue that holds decoded terminate (branch/jump) instructions until their source

---
 rtl/terminate_issue_queue.sv | 189 ++++++++++++++++++
 tb/tb_terminate_issue_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminate_issue_queue.sv
// In-order issue queue for terminate (branch/jump) ops; holds entries until their sources are written.
// Latency: an entry can issue at the earliest one cycle after it is enqueued. Wakeups take effect the following cycle.
// Backpressure: enq_ready is low only when the queue is full, with no path from iss_ready. The head holds while iss_ready is low.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every entry (ROB redirect)
//   enq_*           dispatch side (valid/ready): fields, source tags {flags, base_hi, base_lo}, per-source ready
//   wb_valid/wb_tag two-port writeback broadcast used for wakeup
//   iss_*           head entry toward terminate_pipeline (valid/ready); all zero while iss_valid is low
//   count           number of occupied entries
module terminate_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [3:0]                enq_opcode,
    input  logic [7:0]                enq_offset,
    input  logic [3:0]                enq_imm,
    input  logic [4:0]                enq_rob,
    input  logic [7:0]                enq_arch_dest,
    input  logic [9:0]                enq_phys_dest,
    input  logic [3*TAG_W-1:0]        enq_src_tag,
    input  logic [2:0]                enq_src_rdy,
    input  logic [1:0]                wb_valid,
    input  logic [2*TAG_W-1:0]        wb_tag,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [3:0]                iss_opcode,
    output logic [7:0]                iss_offset,
    output logic [3:0]                iss_imm,
    output logic [4:0]                iss_rob,
    output logic [7:0]                iss_arch_dest,
    output logic [9:0]                iss_phys_dest,
    output logic [3*TAG_W-1:0]        iss_src_tag,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // src_tag[0]=base_lo, [1]=base_hi, [2]=flags, matching the flat port order.
    typedef struct packed {
        logic [3:0]             opcode;
        logic [7:0]             offset;
        logic [3:0]             imm;
        logic [4:0]             rob;
        logic [7:0]             arch_dest;
        logic [9:0]             phys_dest;
        logic [2:0][TAG_W-1:0]  src_tag;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [2:0]      rdy_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    entry_t          enq_ent;
    entry_t          head_ent;
    logic [2:0]      enq_rdy_in;
    logic [2:0]      wake [DEPTH];
    logic            enq_fire;
    logic            iss_fire;

    // ------------------------------------------------------------------
    // Enqueue payload and same-cycle writeback capture
    // ------------------------------------------------------------------
    always_comb begin
        enq_ent           = '0;
        enq_ent.opcode    = enq_opcode;
        enq_ent.offset    = enq_offset;
        enq_ent.imm       = enq_imm;
        enq_ent.rob       = enq_rob;
        enq_ent.arch_dest = enq_arch_dest;
        enq_ent.phys_dest = enq_phys_dest;
        enq_ent.src_tag   = enq_src_tag;
    end

    // A writeback landing in the dispatch cycle would otherwise be missed,
    // since the entry does not exist yet for the stored-tag compare below.
    always_comb begin
        enq_rdy_in = enq_src_rdy;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 2; p++) begin
                if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == enq_ent.src_tag[s])) begin
                    enq_rdy_in[s] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Wakeup of stored entries: plain tag compare, no reserved tag values
    // ------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wake[e] = 3'b000;
            for (int s = 0; s < 3; s++) begin
                for (int p = 0; p < 2; p++) begin
                    if (vld_q[e] && wb_valid[p] &&
                        (wb_tag[p*TAG_W +: TAG_W] == ent_q[e].src_tag[s])) begin
                        wake[e][s] = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshakes. Issue depends only on stored state, so readiness seen by
    // downstream is always one cycle behind the wakeup that caused it.
    // ------------------------------------------------------------------
    assign head_ent  = ent_q[head_q];
    assign iss_valid = vld_q[head_q] & (&rdy_q[head_q]);
    assign enq_ready = (count_q != FULL);
    assign enq_fire  = enq_valid & enq_ready;
    assign iss_fire  = iss_valid & iss_ready;
    assign count     = count_q;

    assign iss_opcode    = iss_valid ? head_ent.opcode    : '0;
    assign iss_offset    = iss_valid ? head_ent.offset    : '0;
    assign iss_imm       = iss_valid ? head_ent.imm       : '0;
    assign iss_rob       = iss_valid ? head_ent.rob       : '0;
    assign iss_arch_dest = iss_valid ? head_ent.arch_dest : '0;
    assign iss_phys_dest = iss_valid ? head_ent.phys_dest : '0;
    assign iss_src_tag   = iss_valid ? head_ent.src_tag   : '0;

    // ------------------------------------------------------------------
    // State. Enqueue is blocked when full, so tail never aliases a live
    // head slot; the enqueue write therefore never collides with issue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rdy_q[e] <= 3'b000;
                ent_q[e] <= '0;
            end
        end else if (flush) begin
            // Payload is left stale; valid/ready clear is enough to hide it.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rdy_q[e] <= 3'b000;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                rdy_q[e] <= rdy_q[e] | wake[e];
            end
            if (iss_fire) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            if (enq_fire) begin
                ent_q[tail_q] <= enq_ent;
                vld_q[tail_q] <= 1'b1;
                rdy_q[tail_q] <= enq_rdy_in;
                tail_q        <= tail_q + PW'(1);
            end
            case ({enq_fire, iss_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Occupancy sanity
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_fire && (count_q == FULL)));
            assert (count_q <= FULL);
            assert (!(iss_fire && (count_q == '0)));
        end
    end

endmodule

// File: tb/tb_terminate_issue_queue.sv
module tb_terminate_issue_queue;

    localparam int TAG_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               enq_valid;
    logic               enq_ready;
    logic [3:0]         enq_opcode;
    logic [7:0]         enq_offset;
    logic [3:0]         enq_imm;
    logic [4:0]         enq_rob;
    logic [7:0]         enq_arch_dest;
    logic [9:0]         enq_phys_dest;
    logic [14:0]        enq_src_tag;
    logic [2:0]         enq_src_rdy;
    logic [1:0]         wb_valid;
    logic [9:0]         wb_tag;
    logic               iss_valid;
    logic               iss_ready;
    logic [3:0]         iss_opcode;
    logic [7:0]         iss_offset;
    logic [3:0]         iss_imm;
    logic [4:0]         iss_rob;
    logic [7:0]         iss_arch_dest;
    logic [9:0]         iss_phys_dest;
    logic [14:0]        iss_src_tag;
    logic [2:0]         count;
    logic [38:0]        iss_fields;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iss_fields = {iss_opcode, iss_offset, iss_imm, iss_rob, iss_arch_dest, iss_phys_dest};

    terminate_issue_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_opcode(enq_opcode), .enq_offset(enq_offset), .enq_imm(enq_imm),
        .enq_rob(enq_rob), .enq_arch_dest(enq_arch_dest), .enq_phys_dest(enq_phys_dest),
        .enq_src_tag(enq_src_tag), .enq_src_rdy(enq_src_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_offset(iss_offset), .iss_imm(iss_imm),
        .iss_rob(iss_rob), .iss_arch_dest(iss_arch_dest), .iss_phys_dest(iss_phys_dest),
        .iss_src_tag(iss_src_tag), .count(count)
    );

    // Distinct payload per instruction id
    function automatic logic [38:0] fields_of(input int id);
        logic [3:0] op;
        logic [7:0] off;
        logic [3:0] imm;
        logic [4:0] rob;
        logic [7:0] arch;
        logic [9:0] phys;
        op   = 4'(id);
        off  = 8'(id * 7 + 3);
        imm  = 4'(15 - (id % 16));
        rob  = 5'(id + 3);
        arch = 8'(160 + id);
        phys = 10'(512 + id * 5);
        return {op, off, imm, rob, arch, phys};
    endfunction

    // {flags, base_hi, base_lo} = {3id+2, 3id+1, 3id} mod 32
    function automatic logic [14:0] tags_of(input int id);
        return {5'((id * 3 + 2) % 32), 5'((id * 3 + 1) % 32), 5'((id * 3) % 32)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input int id, input logic [14:0] tags, input logic [2:0] rdy);
        enq_valid = 1'b1;
        {enq_opcode, enq_offset, enq_imm, enq_rob, enq_arch_dest, enq_phys_dest} = fields_of(id);
        enq_src_tag = tags;
        enq_src_rdy = rdy;
    endtask

    task automatic idle_enq();
        enq_valid = 1'b0;
        {enq_opcode, enq_offset, enq_imm, enq_rob, enq_arch_dest, enq_phys_dest} = '0;
        enq_src_tag = '0;
        enq_src_rdy = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; iss_ready = 1'b0; wb_valid = 2'b00; wb_tag = '0;
        idle_enq();
        tick(); tick();
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        checks++; if ({iss_fields, iss_src_tag} !== 54'd0) begin errors++; $display("FAIL reset_iss_data: got %h want 0", {iss_fields, iss_src_tag}); end
    endtask

    task automatic test_single();
        drive_enq(1, tags_of(1), 3'b111);
        iss_ready = 1'b1;
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL single_empty_valid: got %b want 0", iss_valid); end
        tick();
        idle_enq();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", iss_valid); end
        checks++; if (iss_fields !== fields_of(1)) begin errors++; $display("FAIL single_fields: got %h want %h", iss_fields, fields_of(1)); end
        checks++; if (iss_src_tag !== tags_of(1)) begin errors++; $display("FAIL single_tags: got %h want %h", iss_src_tag, tags_of(1)); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", iss_valid); end
        iss_ready = 1'b0;
    endtask

    task automatic test_head_block();
        logic [14:0] t;
        for (int k = 0; k < 4; k++) begin
            drive_enq(10 + k, tags_of(10 + k), 3'b000);
            tick();
        end
        idle_enq();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL block_count4: got %0d want 4", count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL block_enq_ready: got %b want 0", enq_ready); end
        // Wake all of entry 1 only
        t = tags_of(11);
        wb_valid = 2'b11; wb_tag = {t[9:5], t[4:0]};
        tick();
        wb_valid = 2'b01; wb_tag = {5'd0, t[14:10]};
        tick();
        wb_valid = 2'b00;
        tick();
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL block_head_stalled: got %b want 0", iss_valid); end
        // Wake head; its flags tag is 0
        t = tags_of(10);
        wb_valid = 2'b11; wb_tag = {t[9:5], t[4:0]};
        tick();
        wb_valid = 2'b01; wb_tag = {5'd0, t[14:10]};
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL block_wake_registered: got %b want 0", iss_valid); end
        tick();
        wb_valid = 2'b00;
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL block_head_woken: got %b want 1", iss_valid); end
        for (int k = 12; k < 14; k++) begin
            t = tags_of(k);
            wb_valid = 2'b11; wb_tag = {t[9:5], t[4:0]};
            tick();
            wb_valid = 2'b01; wb_tag = {5'd0, t[14:10]};
            tick();
        end
        wb_valid = 2'b00;
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (iss_valid !== 1'b1 || iss_fields !== fields_of(10 + k))
                begin errors++; $display("FAIL block_drain%0d: got v=%b %h want v=1 %h", k, iss_valid, iss_fields, fields_of(10 + k)); end
            checks++; if (count !== 3'(4 - k)) begin errors++; $display("FAIL block_drain_count%0d: got %0d want %0d", k, count, 4 - k); end
            tick();
        end
        checks++; if (count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL block_empty: got count=%0d v=%b want 0 0", count, iss_valid); end
        iss_ready = 1'b0;
    endtask

    task automatic test_same_cycle_wake();
        logic [14:0] t;
        t = {5'd7, 5'd13, 5'd14};
        drive_enq(20, t, 3'b011);
        wb_valid = 2'b01; wb_tag = {5'd0, 5'd7};
        tick();
        idle_enq();
        wb_valid = 2'b00; wb_tag = '0;
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bypass_wake_valid: got %b want 1", iss_valid); end
        checks++; if (iss_src_tag !== t) begin errors++; $display("FAIL bypass_wake_tags: got %h want %h", iss_src_tag, t); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_wake_count: got %0d want 0", count); end
    endtask

    task automatic test_full_enq_issue();
        for (int k = 0; k < 4; k++) begin
            drive_enq(30 + k, tags_of(30 + k), 3'b111);
            tick();
        end
        drive_enq(34, tags_of(34), 3'b111);
        iss_ready = 1'b1;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b want 0", enq_ready); end
        tick();
        idle_enq();
        iss_ready = 1'b0;
        checks++; if (count !== 3'd3 || iss_fields !== fields_of(31)) begin errors++; $display("FAIL full_blocked_enq: got count=%0d %h want 3 %h", count, iss_fields, fields_of(31)); end
        iss_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd2 || iss_fields !== fields_of(32)) begin errors++; $display("FAIL full_count2: got count=%0d %h want 2 %h", count, iss_fields, fields_of(32)); end
        drive_enq(35, tags_of(35), 3'b111);
        tick();
        idle_enq();
        checks++; if (count !== 3'd2 || iss_fields !== fields_of(33)) begin errors++; $display("FAIL full_pair2: got count=%0d %h want 2 %h", count, iss_fields, fields_of(33)); end
        tick();
        checks++; if (count !== 3'd1 || iss_fields !== fields_of(35)) begin errors++; $display("FAIL full_order35: got count=%0d %h want 1 %h", count, iss_fields, fields_of(35)); end
        drive_enq(36, tags_of(36), 3'b111);
        tick();
        idle_enq();
        checks++; if (count !== 3'd1 || iss_fields !== fields_of(36)) begin errors++; $display("FAIL full_pair1: got count=%0d %h want 1 %h", count, iss_fields, fields_of(36)); end
        tick();
        iss_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive_enq(40 + k, tags_of(40 + k), 3'b111);
            tick();
        end
        idle_enq();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        drive_enq(43, tags_of(43), 3'b111);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_enq();
        checks++; if (count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got count=%0d v=%b want 0 0", count, iss_valid); end
        checks++; if (iss_fields !== 39'd0 || enq_ready !== 1'b1) begin errors++; $display("FAIL flush_outputs: got %h rdy=%b want 0 1", iss_fields, enq_ready); end
        tick();
        checks++; if (count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL flush_enq_lost: got count=%0d v=%b want 0 0", count, iss_valid); end
        drive_enq(44, tags_of(44), 3'b111);
        tick();
        idle_enq();
        checks++; if (iss_valid !== 1'b1 || iss_fields !== fields_of(44)) begin errors++; $display("FAIL flush_reuse: got v=%b %h want 1 %h", iss_valid, iss_fields, fields_of(44)); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive_enq(45 + k, tags_of(45 + k), 3'b111);
            tick();
        end
        idle_enq();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count !== 3'd0 || iss_valid !== 1'b0 || iss_src_tag !== 15'd0)
            begin errors++; $display("FAIL reset_mid: got count=%0d v=%b tags=%h want 0 0 0", count, iss_valid, iss_src_tag); end
    endtask

    task automatic test_stall_wrap();
        drive_enq(50, tags_of(50), 3'b111);
        tick();
        idle_enq();
        for (int c = 0; c < 5; c++) begin
            checks++; if (iss_valid !== 1'b1 || iss_fields !== fields_of(50) || iss_src_tag !== tags_of(50))
                begin errors++; $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", c, iss_valid, iss_fields, fields_of(50)); end
            tick();
        end
        iss_ready = 1'b1;
        tick();
        drive_enq(60, tags_of(60), 3'b111);
        tick();
        for (int k = 1; k < 6; k++) begin
            drive_enq(60 + k, tags_of(60 + k), 3'b111);
            checks++; if (iss_fields !== fields_of(59 + k) || count !== 3'd1)
                begin errors++; $display("FAIL wrap_order%0d: got %h count=%0d want %h 1", k, iss_fields, count, fields_of(59 + k)); end
            tick();
        end
        idle_enq();
        checks++; if (iss_fields !== fields_of(65)) begin errors++; $display("FAIL wrap_last: got %h want %h", iss_fields, fields_of(65)); end
        tick();
        iss_ready = 1'b0;
        checks++; if (count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got count=%0d v=%b want 0 0", count, iss_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_head_block();
        test_same_cycle_wake();
        test_full_enq_issue();
        test_flush();
        test_reset_mid();
        test_stall_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
